// File: rtl/uart_rx_frame_ctrl.sv
// Receive frame controller: parses HEADER/LEN/payload/CHK from the UART
// receiver and releases the payload to the FIFO only after a good checksum.
module uart_rx_frame_ctrl #(
  parameter int         CLK_FREQ      = 50000000,
  parameter int         UART_BPS      = 115200,
  parameter logic [7:0] HEADER        = 8'hA5,
  parameter int         MAX_LEN       = 16,
  parameter int         TIMEOUT_BYTES = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  input  logic       fifo_full,
  output logic       fifo_wr_en,
  output logic [7:0] fifo_wr_data,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;
  localparam int TO_CLKS = TIMEOUT_BYTES * 10 * BPS_CNT;
  localparam int GW = (TO_CLKS > 2) ? $clog2(TO_CLKS) : 1;
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(TO_CLKS - 1);
  localparam logic [7:0] MAX_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAY,
    S_CHK,
    S_DRAIN
  } state_t;

  state_t state, state_nx;

  logic          rx_done_d;
  logic [7:0]    len;
  logic [7:0]    wr_idx;
  logic [7:0]    rd_idx;
  logic [7:0]    chk_acc;
  logic [GW-1:0] gap_cnt;
  logic [7:0]    pbuf [MAX_LEN];

  logic       byte_evt;
  logic       timed;
  logic       gap_hit;
  logic       wr_fire;
  logic       last_wr;
  logic       err_set;
  logic [1:0] err_nx;

  assign byte_evt = rx_done & ~rx_done_d;
  assign timed    = (state == S_LEN) || (state == S_PAY) ||
                    (state == S_CHK);
  // a byte arriving on the expiry cycle wins over the timeout
  assign gap_hit  = timed && !byte_evt && (gap_cnt == GAP_LAST);
  assign wr_fire  = (state == S_DRAIN) && !fifo_full;
  assign last_wr  = wr_fire && (rd_idx == len - 8'd1);

  assign busy         = (state != S_IDLE);
  assign fifo_wr_en   = wr_fire;
  assign fifo_wr_data = wr_fire ? pbuf[rd_idx[IW-1:0]] : 8'd0;

  always_comb begin
    state_nx = state;
    err_set  = 1'b0;
    err_nx   = err_code;
    unique case (state)
      S_IDLE: begin
        if (byte_evt && rx_data == HEADER) state_nx = S_LEN;
      end
      S_LEN: begin
        if (byte_evt) begin
          if (rx_data == 8'd0 || rx_data > MAX_B) begin
            err_set  = 1'b1;
            err_nx   = 2'd0;
            state_nx = S_IDLE;
          end else begin
            state_nx = S_PAY;
          end
        end else if (gap_hit) begin
          err_set  = 1'b1;
          err_nx   = 2'd2;
          state_nx = S_IDLE;
        end
      end
      S_PAY: begin
        if (byte_evt) begin
          if (wr_idx + 8'd1 == len) state_nx = S_CHK;
        end else if (gap_hit) begin
          err_set  = 1'b1;
          err_nx   = 2'd2;
          state_nx = S_IDLE;
        end
      end
      S_CHK: begin
        if (byte_evt) begin
          if (rx_data == chk_acc) begin
            state_nx = S_DRAIN;
          end else begin
            err_set  = 1'b1;
            err_nx   = 2'd1;
            state_nx = S_IDLE;
          end
        end else if (gap_hit) begin
          err_set  = 1'b1;
          err_nx   = 2'd2;
          state_nx = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (last_wr) state_nx = S_IDLE;
        if (byte_evt) begin
          err_set = 1'b1;
          err_nx  = 2'd3;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= S_IDLE;
      rx_done_d <= 1'b1;
      len       <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      chk_acc   <= '0;
      gap_cnt   <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      state     <= state_nx;
      rx_done_d <= rx_done;
      frame_ok  <= last_wr;
      frame_err <= err_set;
      if (err_set) err_code <= err_nx;
      if (!timed || byte_evt || gap_hit) gap_cnt <= '0;
      else gap_cnt <= gap_cnt + 1'b1;
      if (state == S_LEN && byte_evt) begin
        len     <= rx_data;
        chk_acc <= rx_data;
        wr_idx  <= '0;
      end
      if (state == S_PAY && byte_evt) begin
        chk_acc <= chk_acc ^ rx_data;
        wr_idx  <= wr_idx + 8'd1;
      end
      if (state == S_CHK && byte_evt) rd_idx <= '0;
      if (wr_fire) rd_idx <= rd_idx + 8'd1;
    end
  end

  // payload store is intentionally left uncleared by reset
  always_ff @(posedge sys_clk) begin
    if (!sys_rst && state == S_PAY && byte_evt)
      pbuf[wr_idx[IW-1:0]] <= rx_data;
  end

endmodule
